// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one W-bit add/sub unit between two requesters.
// Optional op counter output enabled by defining ALU_SHARE_ARBITER_OPCNT_EN.
module alu_share_arbiter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         op0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic         req1,
    input  logic         op1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         done0,
    output logic         done1,
    output logic [W-1:0] result,
    output logic         busy,
    output logic         alu_enable,
    output logic         alu_select,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
`ifdef ALU_SHARE_ARBITER_OPCNT_EN
    output logic [7:0]   op_count,
`endif
    input  logic [W-1:0] alu_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           last_served_q, last_served_d;
    logic           winner_q, winner_d;
    logic           done0_q, done0_d;
    logic           done1_q, done1_d;
    logic           busy_q, busy_d;
    logic           enable_q, enable_d;
    logic           select_q, select_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   result_q, result_d;
    logic [7:0]     op_count_q, op_count_d;

    // Next-state and next-output computation for the grant/execute/complete sequence
    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        winner_d      = winner_q;
        done0_d       = 1'b0;
        done1_d       = 1'b0;
        busy_d        = busy_q;
        enable_d      = enable_q;
        select_d      = select_q;
        a_d           = a_q;
        b_d           = b_q;
        result_d      = result_q;
        op_count_d    = op_count_q;
        case (state_q)
            IDLE: begin
                // Requester 0 wins when alone, or on a tie if requester 1 went last
                if (req0 && (!req1 || last_served_q)) begin
                    winner_d = 1'b0;
                    select_d = op0;
                    a_d      = a0;
                    b_d      = b0;
                    enable_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = EXEC;
                end else if (req1) begin
                    winner_d = 1'b1;
                    select_d = op1;
                    a_d      = a1;
                    b_d      = b1;
                    enable_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = EXEC;
                end else begin
                    enable_d = 1'b0;
                    busy_d   = 1'b0;
                end
            end
            EXEC: begin
                result_d = alu_result;
                enable_d = 1'b0;
                done0_d  = ~winner_q;
                done1_d  = winner_q;
                state_d  = DONE;
            end
            DONE: begin
                last_served_d = winner_q;
                busy_d        = 1'b0;
                op_count_d    = op_count_q + 8'd1;
                state_d       = IDLE;
            end
            default: begin
                enable_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and registered-output flops with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_served_q <= 1'b1;
            winner_q      <= 1'b0;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            busy_q        <= 1'b0;
            enable_q      <= 1'b0;
            select_q      <= 1'b0;
            a_q           <= {W{1'b0}};
            b_q           <= {W{1'b0}};
            result_q      <= {W{1'b0}};
            op_count_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            winner_q      <= winner_d;
            done0_q       <= done0_d;
            done1_q       <= done1_d;
            busy_q        <= busy_d;
            enable_q      <= enable_d;
            select_q      <= select_d;
            a_q           <= a_d;
            b_q           <= b_d;
            result_q      <= result_d;
            op_count_q    <= op_count_d;
        end
    end

    assign done0      = done0_q;
    assign done1      = done1_q;
    assign result     = result_q;
    assign busy       = busy_q;
    assign alu_enable = enable_q;
    assign alu_select = select_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;

`ifdef ALU_SHARE_ARBITER_OPCNT_EN
    assign op_count = op_count_q;
`else
    logic unused_op_count_s;
    assign unused_op_count_s = ^op_count_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter, with a behavioural model of the shared add/sub unit.
module tb_alu_share_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, op0, req1, op1;
    logic [3:0] a0, b0, a1, b1;
    logic       done0, done1, busy, alu_enable, alu_select;
    logic [3:0] result, alu_a, alu_b, alu_result;
`ifdef ALU_SHARE_ARBITER_OPCNT_EN
    logic [7:0] op_count;
`endif

    int checks   = 0;
    int failures = 0;

    alu_share_arbiter #(.W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .op0        (op0),
        .a0         (a0),
        .b0         (b0),
        .req1       (req1),
        .op1        (op1),
        .a1         (a1),
        .b1         (b1),
        .done0      (done0),
        .done1      (done1),
        .result     (result),
        .busy       (busy),
        .alu_enable (alu_enable),
        .alu_select (alu_select),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
`ifdef ALU_SHARE_ARBITER_OPCNT_EN
        .op_count   (op_count),
`endif
        .alu_result (alu_result)
    );

    // Shared lab unit: combinational add/sub, all ones when disabled
    assign alu_result = alu_enable ? (alu_select ? (alu_a - alu_b) : (alu_a + alu_b)) : 4'hF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; op0 = 1'b0; a0 = 4'd0; b0 = 4'd0;
        req1 = 1'b0; op1 = 1'b0; a1 = 4'd0; b1 = 4'd0;
        tick();
        tick();
        check("rst_busy",   {7'd0, busy},       8'd0);
        check("rst_done0",  {7'd0, done0},      8'd0);
        check("rst_done1",  {7'd0, done1},      8'd0);
        check("rst_enable", {7'd0, alu_enable}, 8'd0);
        check("rst_select", {7'd0, alu_select}, 8'd0);
        check("rst_a",      {4'd0, alu_a},      8'd0);
        check("rst_b",      {4'd0, alu_b},      8'd0);
        check("rst_result", {4'd0, result},     8'd0);
        rst = 1'b0;

        // 3 + 4 from requester 0: EXEC in cycle 1, done in cycle 2, idle in cycle 3
        req0 = 1'b1; op0 = 1'b0; a0 = 4'd3; b0 = 4'd4;
        tick();
        check("t1_enable", {7'd0, alu_enable}, 8'd1);
        check("t1_busy1",  {7'd0, busy},       8'd1);
        check("t1_alu_a",  {4'd0, alu_a},      8'd3);
        check("t1_alu_b",  {4'd0, alu_b},      8'd4);
        check("t1_done0a", {7'd0, done0},      8'd0);
        req0 = 1'b0;
        tick();
        check("t1_done0",   {7'd0, done0},      8'd1);
        check("t1_done1",   {7'd0, done1},      8'd0);
        check("t1_result",  {4'd0, result},     8'd7);
        check("t1_enoff",   {7'd0, alu_enable}, 8'd0);
        check("t1_busy2",   {7'd0, busy},       8'd1);
        tick();
        check("t1_busy3",   {7'd0, busy},       8'd0);
        check("t1_done0c",  {7'd0, done0},      8'd0);
        check("t1_hold",    {4'd0, result},     8'd7);
        check("t1_ahold",   {4'd0, alu_a},      8'd3);

        // 2 - 5 from requester 1 wraps to D
        req1 = 1'b1; op1 = 1'b1; a1 = 4'd2; b1 = 4'd5;
        tick();
        check("t2_select", {7'd0, alu_select}, 8'd1);
        req1 = 1'b0;
        tick();
        check("t2_done1",  {7'd0, done1},  8'd1);
        check("t2_done0",  {7'd0, done0},  8'd0);
        check("t2_result", {4'd0, result}, 8'hD);
        tick();
        // F + 1 wraps to 0
        req1 = 1'b1; op1 = 1'b0; a1 = 4'hF; b1 = 4'd1;
        tick();
        req1 = 1'b0;
        tick();
        check("t2b_done1",  {7'd0, done1},  8'd1);
        check("t2b_result", {4'd0, result}, 8'h0);
        tick();

        // Both requesting from reset: grants alternate 0,1,0,1 three cycles apart
        rst = 1'b1;
        op0 = 1'b0; a0 = 4'd1; b0 = 4'd2;
        op1 = 1'b1; a1 = 4'd9; b1 = 4'd4;
        req0 = 1'b1; req1 = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("rr_done0_c%0d", i), {7'd0, done0}, {7'd0, (i % 6) == 2});
            check($sformatf("rr_done1_c%0d", i), {7'd0, done1}, {7'd0, (i % 6) == 5});
            if ((i % 6) == 2) begin
                check($sformatf("rr_res0_c%0d", i), {4'd0, result}, 8'd3);
            end else if ((i % 6) == 5) begin
                check($sformatf("rr_res1_c%0d", i), {4'd0, result}, 8'd5);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        check("rr_idle_busy", {7'd0, busy}, 8'd0);

        // Operand change after grant must not affect the in-flight op
        req0 = 1'b1; op0 = 1'b0; a0 = 4'd3; b0 = 4'd4;
        tick();
        a0 = 4'd9; req0 = 1'b0;
        tick();
        check("late_a_done0",  {7'd0, done0},  8'd1);
        check("late_a_result", {4'd0, result}, 8'd7);
        tick();

        // 0 - 1 wraps to F
        req0 = 1'b1; op0 = 1'b1; a0 = 4'd0; b0 = 4'd1;
        tick();
        req0 = 1'b0;
        tick();
        check("sub_wrap", {4'd0, result}, 8'hF);
        tick();

        // Reset during EXEC aborts with no done pulse
        req0 = 1'b1; op0 = 1'b0; a0 = 4'd3; b0 = 4'd4;
        tick();
        check("abort_exec", {7'd0, alu_enable}, 8'd1);
        req0 = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_result", {4'd0, result},     8'd0);
        check("abort_busy",   {7'd0, busy},       8'd0);
        check("abort_enable", {7'd0, alu_enable}, 8'd0);
        tick();
        rst = 1'b0;
        tick();
        check("abort_done0", {7'd0, done0}, 8'd0);
        check("abort_idle",  {7'd0, busy},  8'd0);
        req0 = 1'b1; a0 = 4'd2; b0 = 4'd2;
        tick();
        check("post_abort_grant", {7'd0, alu_enable}, 8'd1);
        req0 = 1'b0;
        tick();
        check("post_abort_done0", {7'd0, done0},  8'd1);
        check("post_abort_res",   {4'd0, result}, 8'd4);
        tick();

`ifdef ALU_SHARE_ARBITER_OPCNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("cnt_reset", op_count, 8'd0);
        req0 = 1'b1; op0 = 1'b0; a0 = 4'd1; b0 = 4'd1;
        for (int n = 0; n < 255 * 3; n++) begin
            tick();
        end
        check("cnt_255", op_count, 8'd255);
        for (int n = 0; n < 3; n++) begin
            tick();
        end
        check("cnt_wrap", op_count, 8'd0);
        req0 = 1'b0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the lab's single 4-bit add/sub unit between two requesters.
- The shared unit is combinational with enable, select (0 = add, 1 = sub), two 4-bit operands and a 4-bit result; it drives 4'b1111 when disabled.
- This block latches a winning request and drives the unit for one cycle. It then captures the result and returns it to the winner with a one-cycle done pulse.

Parameters:
- W, 4, operand/result width; must match the shared unit (fixed at 4 in this lab).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req0  input  1  requester 0 request, level
- op0  input  1  requester 0 operation, 0 = add, 1 = sub
- a0  input  W  requester 0 operand A
- b0  input  W  requester 0 operand B
- req1  input  1  requester 1 request, level
- op1  input  1  requester 1 operation
- a1  input  W  requester 1 operand A
- b1  input  W  requester 1 operand B
- done0  output  1  one-cycle pulse: requester 0's result valid
- done1  output  1  one-cycle pulse: requester 1's result valid
- result  output  W  captured result; valid while done0/done1 high
- busy  output  1  high in EXEC and DONE
- alu_enable  output  1  to shared unit enable
- alu_select  output  1  to shared unit select
- alu_a  output  W  to shared unit operand A
- alu_b  output  W  to shared unit operand B
- alu_result  input  W  from shared unit result

Behaviour:
- States: IDLE, EXEC, DONE. All outputs are registered.
- Reset (async, any state): state = IDLE, last_served = 1 (so requester 0 wins the first tie). done0/done1/busy/alu_enable/alu_select = 0; alu_a/alu_b/result = 0.
- IDLE, no req: stay. alu_enable = 0.
- IDLE, exactly one req high: grant it.
- IDLE, both req high: grant the requester != last_served.
- On grant: latch op/a/b into alu_select/alu_a/alu_b, set alu_enable = 1, record the winner, go to EXEC.
- EXEC (one cycle): alu_enable = 1. At the clock edge, result <= alu_result, alu_enable <= 0, go to DONE.
- DONE (one cycle): done of the winner = 1, the other done = 0. last_served <= winner. Go to IDLE.
- Latency: req sampled high in cycle 0 → EXEC in cycle 1 → done in cycle 2 → IDLE in cycle 3. Maximum throughput is one op per 3 cycles.
- Requests are ignored in EXEC/DONE. A req still high on return to IDLE counts as a new request.
- Operand or op changes after grant have no effect on the in-flight op.
- Arithmetic is modulo 2^W: wrap-around, no carry/borrow output. Example: 4'hF + 4'h1 = 4'h0; 4'h0 - 4'h1 = 4'hF.
- result holds its value between DONE cycles. alu_a/alu_b/alu_select hold their last values while alu_enable = 0.
- Reset in EXEC or DONE: transaction aborted, no done pulse, result = 0.
- done0 and done1 are never high in the same cycle.

Optional Feature:
- Macro: ALU_SHARE_ARBITER_OPCNT_EN.
- Defined: adds output op_count [7:0]. Increments by 1 on every DONE cycle, wraps 255→0, reset to 0.
- Undefined: op_count port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then req0=1, op0=0, a0=3, b0=4 → alu_enable=1 in cycle 1; done0=1, result=7 in cycle 2; busy low in cycle 3.
- req1=1, op1=1, a1=2, b1=5 → done1 pulse with result=4'hD; a1=4'hF, b1=1, op1=0 → result=0.
- req0 and req1 both held high from reset → grants alternate 0,1,0,1; done pulses 3 cycles apart, starting with done0.
- Change a0 from 3 to 9 during EXEC of a 3+4 request → result=7.
- Assert rst during EXEC → no done pulse; result=0, busy=0 immediately; state IDLE after release.
- With ALU_SHARE_ARBITER_OPCNT_EN defined, 256 completed ops → op_count returns to 0.
